// File: rtl/ldst_control_sequencer.sv
// Moore control sequencer for the ld / ldi / st instruction class.
// Strobes are registered images of the next state, so they only ever change on a Clock rise or on Reset.
module ldst_control_sequencer #(
  parameter int                  OPCODE_W       = 5,
  parameter int                  WAIT_CYCLES    = 0,
  parameter int                  TIMEOUT_CYCLES = 16,
  parameter logic [OPCODE_W-1:0] OP_LD          = 5'b00000,
  parameter logic [OPCODE_W-1:0] OP_LDI         = 5'b00001,
  parameter logic [OPCODE_W-1:0] OP_ST          = 5'b00010
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Run,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Mem_ready,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                BAout,
  output logic                Cout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Rin,
  output logic                Gra,
  output logic                Grb,
  output logic                IncPC,
  output logic                Read,
  output logic                Write,
  output logic                Fault,
  output logic                Busy,
  output logic [3:0]          State
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_T0    = 4'd7;
  localparam logic [3:0] S_T1    = 4'd8;
  localparam logic [3:0] S_T2    = 4'd9;
  localparam logic [3:0] S_T3    = 4'd10;
  localparam logic [3:0] S_T4    = 4'd11;
  localparam logic [3:0] S_T5    = 4'd12;
  localparam logic [3:0] S_T6    = 4'd13;
  localparam logic [3:0] S_T7    = 4'd14;
  localparam logic [3:0] S_FAULT = 4'd15;

  localparam int B_WRITE  = 0;
  localparam int B_READ   = 1;
  localparam int B_INCPC  = 2;
  localparam int B_GRB    = 3;
  localparam int B_GRA    = 4;
  localparam int B_RIN    = 5;
  localparam int B_ZIN    = 6;
  localparam int B_YIN    = 7;
  localparam int B_IRIN   = 8;
  localparam int B_MDRIN  = 9;
  localparam int B_MARIN  = 10;
  localparam int B_PCIN   = 11;
  localparam int B_COUT   = 12;
  localparam int B_BAOUT  = 13;
  localparam int B_MDROUT = 14;
  localparam int B_ZLOW   = 15;
  localparam int B_PCOUT  = 16;
  localparam int B_BUSY   = 17;
  localparam int B_FAULT  = 18;

  localparam int              TO_LAST_I = TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0]   TO_LAST   = TO_LAST_I[CW-1:0];
  localparam logic [CW:0]     WAIT_P    = WAIT_CYCLES[CW:0];
  localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};

  logic [3:0]          state_r;
  logic [3:0]          state_nxt_s;
  logic [3:0]          target_s;
  logic [3:0]          next_instr_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_nxt_s;
  logic [OPCODE_W-1:0] op_r;
  logic [OPCODE_W-1:0] op_nxt_s;
  logic [18:0]         out_r;
  logic                op_ld_s;
  logic                op_st_s;
  logic                op_ldi_s;
  logic                op_known_s;
  logic                mem_s;
  logic                wait_met_s;
  logic                exit_s;

  // Strobe/flag image of a state; T1 drives PCin only on its first cycle.
  function automatic logic [18:0] decode(input logic [3:0] st, input logic [CW-1:0] cnt,
                                         input logic [OPCODE_W-1:0] op);
    logic [18:0] v;
    v = 19'd0;
    v[B_BUSY] = 1'b1;
    case (st)
      S_T0: begin v[B_PCOUT] = 1'b1; v[B_MARIN] = 1'b1; v[B_INCPC] = 1'b1; v[B_ZIN] = 1'b1; end
      S_T1: begin
        v[B_READ] = 1'b1; v[B_MDRIN] = 1'b1; v[B_ZLOW] = 1'b1;
        v[B_PCIN] = (cnt == {CW{1'b0}});
      end
      S_T2: begin v[B_MDROUT] = 1'b1; v[B_IRIN] = 1'b1; end
      S_T3: begin v[B_GRB] = 1'b1; v[B_BAOUT] = 1'b1; v[B_YIN] = 1'b1; end
      S_T4: begin v[B_COUT] = 1'b1; v[B_ZIN] = 1'b1; end
      S_T5: begin
        v[B_ZLOW] = 1'b1;
        if (op == OP_LDI) begin v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        else              begin v[B_MARIN] = 1'b1; end
      end
      S_T6: begin
        if (op == OP_LD) begin v[B_READ] = 1'b1; v[B_MDRIN] = 1'b1; end
        else             begin v[B_GRA] = 1'b1; v[B_BAOUT] = 1'b1; v[B_MDRIN] = 1'b1; end
      end
      S_T7: begin
        if (op == OP_LD) begin v[B_MDROUT] = 1'b1; v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; end
        else             begin v[B_WRITE] = 1'b1; end
      end
      S_FAULT: begin v[B_BUSY] = 1'b0; v[B_FAULT] = 1'b1; end
      default: v[B_BUSY] = 1'b0;
    endcase
    return v;
  endfunction

  assign op_ld_s      = (op_r == OP_LD);
  assign op_st_s      = (op_r == OP_ST);
  assign op_ldi_s     = (op_r == OP_LDI);
  assign op_known_s   = (Opcode == OP_LD) || (Opcode == OP_LDI) || (Opcode == OP_ST);
  assign next_instr_s = Run ? S_T0 : S_IDLE;
  assign mem_s        = (state_r == S_T1) || ((state_r == S_T6) && op_ld_s) || ((state_r == S_T7) && op_st_s);
  // Written as cnt+1 > WAIT so the compare stays meaningful when WAIT_CYCLES is 0.
  assign wait_met_s   = (({1'b0, cnt_r} + {{CW{1'b0}}, 1'b1}) > WAIT_P);
  assign exit_s       = Mem_ready && wait_met_s;

  // Next-state, wait counter and opcode latch selection.
  always_comb begin
    target_s  = S_IDLE;
    op_nxt_s  = op_r;
    case (state_r)
      S_IDLE:  target_s = Run ? S_T0 : S_IDLE;
      S_T0:    target_s = S_T1;
      S_T1:    target_s = S_T2;
      S_T2:    target_s = S_T3;
      S_T3: begin
        op_nxt_s = Opcode;
        target_s = op_known_s ? S_T4 : next_instr_s;
      end
      S_T4:    target_s = S_T5;
      S_T5:    target_s = op_ldi_s ? next_instr_s : S_T6;
      S_T6:    target_s = S_T7;
      S_T7:    target_s = next_instr_s;
      S_FAULT: target_s = S_FAULT;
      default: target_s = S_IDLE;
    endcase

    if (!mem_s) begin
      state_nxt_s = target_s;
    end else if (exit_s) begin
      state_nxt_s = target_s;
    end else if (cnt_r == TO_LAST) begin
      state_nxt_s = S_FAULT;
    end else begin
      state_nxt_s = state_r;
    end

    if (mem_s && (state_nxt_s == state_r)) begin
      cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = {CW{1'b0}};
    end
  end

  // State, counter, latched opcode and registered output image.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= {OPCODE_W{1'b0}};
      out_r   <= 19'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      op_r    <= op_nxt_s;
      out_r   <= decode(state_nxt_s, cnt_nxt_s, op_nxt_s);
    end
  end

  assign PCout   = out_r[B_PCOUT];
  assign Zlowout = out_r[B_ZLOW];
  assign MDRout  = out_r[B_MDROUT];
  assign BAout   = out_r[B_BAOUT];
  assign Cout    = out_r[B_COUT];
  assign PCin    = out_r[B_PCIN];
  assign MARin   = out_r[B_MARIN];
  assign MDRin   = out_r[B_MDRIN];
  assign IRin    = out_r[B_IRIN];
  assign Yin     = out_r[B_YIN];
  assign Zin     = out_r[B_ZIN];
  assign Rin     = out_r[B_RIN];
  assign Gra     = out_r[B_GRA];
  assign Grb     = out_r[B_GRB];
  assign IncPC   = out_r[B_INCPC];
  assign Read    = out_r[B_READ];
  assign Write   = out_r[B_WRITE];
  assign Busy    = out_r[B_BUSY];
  assign Fault   = out_r[B_FAULT];
  assign State   = state_r;

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// Bench for ldst_control_sequencer: two instances (WAIT_CYCLES 0 and 2) checked against an
// instruction-level model that expands each opcode into its phase list and times memory phases.
module tb_ldst_control_sequencer;

  localparam int TO = 16;
  localparam int P_ALWAYS = 0, P_RAND = 1, P_PULSE = 2, P_STUCK = 3;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;

  localparam logic [16:0] M_PCOUT = 17'h10000, M_ZLOW  = 17'h08000, M_MDROUT = 17'h04000;
  localparam logic [16:0] M_BAOUT = 17'h02000, M_COUT  = 17'h01000, M_PCIN   = 17'h00800;
  localparam logic [16:0] M_MARIN = 17'h00400, M_MDRIN = 17'h00200, M_IRIN   = 17'h00100;
  localparam logic [16:0] M_YIN   = 17'h00080, M_ZIN   = 17'h00040, M_RIN    = 17'h00020;
  localparam logic [16:0] M_GRA   = 17'h00010, M_GRB   = 17'h00008, M_INCPC  = 17'h00004;
  localparam logic [16:0] M_READ  = 17'h00002, M_WRITE = 17'h00001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] run;
  logic [1:0] rdy;
  logic [4:0] opc [2];
  wire [16:0] strb [2];
  wire [3:0]  st [2];
  wire [1:0]  flt;
  wire [1:0]  bsy;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ldst_control_sequencer #(.WAIT_CYCLES(g * 2), .TIMEOUT_CYCLES(TO)) u_dut (
      .Clock(clk), .Reset(rst_n), .Run(run[g]), .Opcode(opc[g]), .Mem_ready(rdy[g]),
      .PCout(strb[g][16]), .Zlowout(strb[g][15]), .MDRout(strb[g][14]), .BAout(strb[g][13]),
      .Cout(strb[g][12]), .PCin(strb[g][11]), .MARin(strb[g][10]), .MDRin(strb[g][9]),
      .IRin(strb[g][8]), .Yin(strb[g][7]), .Zin(strb[g][6]), .Rin(strb[g][5]),
      .Gra(strb[g][4]), .Grb(strb[g][3]), .IncPC(strb[g][2]), .Read(strb[g][1]),
      .Write(strb[g][0]), .Fault(flt[g]), .Busy(bsy[g]), .State(st[g])
    );
  end

  // Expected strobes per phase; cls 0=ld 1=ldi 2=st 3=other.
  function automatic logic [16:0] exp_strb(input int p, input int cls, input bit first);
    case (p)
      7:  return M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
      8:  return M_READ | M_MDRIN | M_ZLOW | (first ? M_PCIN : 17'h0);
      9:  return M_MDROUT | M_IRIN;
      10: return M_GRB | M_BAOUT | M_YIN;
      11: return M_COUT | M_ZIN;
      12: return (cls == 1) ? (M_ZLOW | M_GRA | M_RIN) : (M_ZLOW | M_MARIN);
      13: return (cls == 0) ? (M_READ | M_MDRIN) : (M_GRA | M_BAOUT | M_MDRIN);
      14: return (cls == 0) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
      default: return 17'h0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int d, input int es, input logic [16:0] estrb, input bit eb, input bit ef,
                     input string tag);
    checks++;
    assert (st[d] === 4'(es)) else begin
      failures++; $error("FAIL %s dut%0d state observed=%0d expected=%0d", tag, d, st[d], es);
    end
    checks++;
    assert (strb[d] === estrb) else begin
      failures++; $error("FAIL %s dut%0d strobes state=%0d observed=%h expected=%h", tag, d, es, strb[d], estrb);
    end
    checks++;
    assert (bsy[d] === eb) else begin
      failures++; $error("FAIL %s dut%0d Busy state=%0d observed=%b expected=%b", tag, d, es, bsy[d], eb);
    end
    checks++;
    assert (flt[d] === ef) else begin
      failures++; $error("FAIL %s dut%0d Fault state=%0d observed=%b expected=%b", tag, d, es, flt[d], ef);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Asserts Reset between clock edges and expects everything cleared before the next edge.
  task automatic async_reset(input int d);
    #2;
    rst_n = 1'b0;
    #1;
    chk(d, 0, 17'h0, 1'b0, 1'b0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start(input int d);
    chk(d, 0, 17'h0, 1'b0, 1'b0, "idle");
    run[d] = 1'b1;
    rdy[d] = 1'($urandom % 2);
    cyc();
  endtask

  task automatic recover(input int d);
    for (int i = 0; i < 3; i++) begin
      run[d] = 1'($urandom % 2);
      rdy[d] = 1'b1;
      cyc();
      chk(d, 15, 17'h0, 1'b0, 1'b1, "fault_hold");
    end
    run[d] = 1'b0;
    async_reset(d);
    cyc();
  endtask

  // Runs one instruction from T0; returns cycles spent and whether a timeout fault was expected.
  task automatic exec(input int d, input logic [4:0] op, input bit keep, input int pat, input int abort_p,
                      output int ncyc, output bit faulted);
    int ph[$];
    int cls, p, k, w;
    bit mem, last, done;
    logic rbit;
    w = (d == 1) ? 2 : 0;
    cls = (op == OP_LD) ? 0 : (op == OP_LDI) ? 1 : (op == OP_ST) ? 2 : 3;
    ph = {7, 8, 9, 10};
    if (cls != 3) begin ph.push_back(11); ph.push_back(12); end
    if (cls == 0 || cls == 2) begin ph.push_back(13); ph.push_back(14); end
    ncyc = 0;
    faulted = 1'b0;
    for (int i = 0; i < ph.size(); i++) begin
      p = ph[i];
      mem = (p == 8) || (p == 13 && cls == 0) || (p == 14 && cls == 2);
      last = (i == ph.size() - 1);
      k = 0;
      done = 1'b0;
      while (!done) begin
        chk(d, p, exp_strb(p, cls, k == 0), 1'b1, 1'b0, "exec");
        if (p == abort_p) begin
          run[d] = 1'b1;
          async_reset(d);
          ncyc = -1;
          return;
        end
        if (!mem) rbit = 1'($urandom % 2);
        else begin
          case (pat)
            P_ALWAYS: rbit = 1'b1;
            P_RAND:   rbit = 1'(($urandom % 100) < 60);
            P_PULSE:  rbit = 1'((k == 0) || (k >= 4));
            default:  rbit = last ? 1'b0 : 1'b1;
          endcase
        end
        rdy[d] = rbit;
        opc[d] = (p == 10) ? op : 5'($urandom);
        run[d] = last ? keep : 1'($urandom % 2);
        ncyc++;
        cyc();
        if (!mem) done = 1'b1;
        else if (rbit && k >= w) done = 1'b1;
        else if (k == TO - 1) begin
          chk(d, 15, 17'h0, 1'b0, 1'b1, "timeout");
          faulted = 1'b1;
          return;
        end else k++;
      end
    end
  endtask

  task automatic rand_run(input int d, input int count);
    bit in_t0, keep, f;
    int n;
    logic [4:0] op;
    in_t0 = 1'b0;
    for (int i = 0; i < count; i++) begin
      if (!in_t0) start(d);
      case ($urandom % 4)
        0: op = OP_LD;
        1: op = OP_LDI;
        2: op = OP_ST;
        default: op = 5'($urandom);
      endcase
      keep = 1'($urandom % 2);
      exec(d, op, keep, P_RAND, -1, n, f);
      if (f) begin
        recover(d);
        in_t0 = 1'b0;
      end else in_t0 = keep;
    end
    if (in_t0) exec(d, 5'h1F, 1'b0, P_ALWAYS, -1, n, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit f;
    rst_n = 1'b0;
    run = 2'b00;
    rdy = 2'b00;
    opc[0] = 5'd0;
    opc[1] = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk(0, 0, 17'h0, 1'b0, 1'b0, "reset");
    chk(1, 0, 17'h0, 1'b0, 1'b0, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 2'b11;
    cyc();
    chk(0, 0, 17'h0, 1'b0, 1'b0, "idle_no_run");
    chk(1, 0, 17'h0, 1'b0, 1'b0, "idle_no_run");

    start(0);
    exec(0, OP_ST, 1'b0, P_ALWAYS, -1, n, f);
    chk_int("st_cycles", n, 8);
    start(0);
    exec(0, OP_LD, 1'b1, P_ALWAYS, -1, n, f);
    chk_int("ld_cycles", n, 8);
    exec(0, OP_LDI, 1'b1, P_ALWAYS, -1, n, f);
    chk_int("ldi_cycles", n, 6);
    exec(0, 5'h1F, 1'b1, P_ALWAYS, -1, n, f);
    chk_int("unknown_cycles", n, 4);
    exec(0, 5'h05, 1'b0, P_ALWAYS, -1, n, f);
    chk_int("unknown_stop_cycles", n, 4);

    rand_run(0, 25);

    start(0);
    exec(0, OP_ST, 1'b1, P_STUCK, -1, n, f);
    chk_int("st_timeout_fault", int'(f), 1);
    chk_int("st_timeout_cycles", n, 7 + TO);
    recover(0);

    start(0);
    exec(0, OP_LD, 1'b1, P_ALWAYS, 13, n, f);
    cyc();
    exec(0, OP_LD, 1'b0, P_ALWAYS, -1, n, f);
    chk_int("ld_after_reset_cycles", n, 8);

    start(1);
    exec(1, OP_LD, 1'b1, P_ALWAYS, -1, n, f);
    chk_int("ld_wait2_cycles", n, 12);
    exec(1, OP_ST, 1'b1, P_ALWAYS, -1, n, f);
    chk_int("st_wait2_cycles", n, 12);
    exec(1, OP_LD, 1'b0, P_PULSE, -1, n, f);
    chk_int("ld_wait2_pulse_cycles", n, 16);

    rand_run(1, 12);
    chk(0, 0, 17'h0, 1'b0, 1'b0, "final_idle");
    chk(1, 0, 17'h0, 1'b0, 1'b0, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
